sw_conditioner: RTL
===================

# sw_conditioner

Input-conditioning stage directly upstream of the five-input minterm decoder (`m_1`). It receives five raw, asynchronous switch or pushbutton levels. For each line it synchronises, debounces and registers the level, then presents clean X, Y, Z, K and M levels to the decoder. It also gives a one-cycle change strobe and a freeze control, so the decoder output can be held steady for display or scoring.

## Interface
- `DEBOUNCE`, default 50000: consecutive stable cycles required to accept a new level. Legal range is 1 to 2^CNT_W−1.
- `CNT_W`, default 16: width of each per-bit debounce counter.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sw_in`  in  5  raw asynchronous levels. Bit mapping: [4]=X, [3]=Y, [2]=Z, [1]=K, [0]=M.
- `freeze`  in  1  synchronous; 1 = hold the outputs at their current value.
- `X`, `Y`, `Z`, `K`, `M`  out  1 each  registered, debounced levels to the decoder.
- `chg`  out  1  one-cycle pulse whenever the output vector {X,Y,Z,K,M} changes value.
- `busy`  out  1  high while any bit's debounce counter is non-zero.

## Operation
- **Synchroniser.** Each bit passes through a 2-FF synchroniser, `s1` then `s2`. Both stages reset to 0.
- **Debounce state.** Each bit has its own accepted level `stb[i]` and counter `cnt[i]` (CNT_W bits). Both reset to 0.
- **Debounce rule**, evaluated each edge and independently per bit:
  - `s2[i] == stb[i]`: `cnt[i]` <= 0.
  - `s2[i] != stb[i]` and `cnt[i] < DEBOUNCE−1`: `cnt[i]` <= `cnt[i]`+1.
  - `s2[i] != stb[i]` and `cnt[i] == DEBOUNCE−1`: `stb[i]` <= `s2[i]`, `cnt[i]` <= 0.
- **Glitch rejection.** A mismatch lasting fewer than DEBOUNCE cycles never reaches `stb` and leaves `cnt` at 0.
- **Counter range.** `cnt` never exceeds DEBOUNCE−1, so no wrap-around is possible.
- **Output register** `out[4:0]`:
  - `freeze=0`: `out` <= `stb`.
  - `freeze=1`: `out` holds its value.
  - `stb` keeps tracking the inputs while frozen. When freeze deasserts, `out` picks up the current `stb` on the next edge.
- **Change strobe.** `chg` is registered and goes high in the same cycle `out` takes a value different from its previous value. A second change on the next edge gives a second pulse; pulses are not merged.
- **Release from freeze.** If `stb` equals the held `out` when freeze deasserts, no `chg` pulse occurs.
- **Busy flag.** `busy` = OR over i of (`cnt[i]` != 0). It is combinational from the counters.
- **Multiple bits.** Several bits qualifying on the same edge update `out` together and produce a single `chg` pulse.
- **Reset mid-debounce.** All counters, `stb`, `out` and `chg` clear immediately. After release, a held-high input is re-debounced from zero.

## Timing
- **Reset values.** X, Y, Z, K, M = 0; `chg` = 0; `busy` = 0. These apply asynchronously on `rst_n`=0.
- **Latency.** Count edge 1 as the first rising edge that samples a new stable level into `s1`.
  - `s2` updates at edge 2.
  - `cnt` counts on edges 3..D+1.
  - `stb` updates at edge D+2.
  - `out` and `chg` update at edge D+3, with `freeze`=0.
- **`chg` width.** Exactly one `clk` cycle.
- **`busy` timing.** Rises at edge 3 and falls at edge D+2.
- **Freeze timing.** `freeze` is sampled on the same edge as the `out` update. Asserting it on the edge where `out` would change blocks that change, and no `chg` is issued.
- **Throughput.** The block is always ready: no backpressure and no input handshake.

## Test plan
All runs use DEBOUNCE=4 and CNT_W=3.
- **Reset.** Hold `rst_n`=0 with `sw_in`=5'b11111, then release. Required: outputs stay 0 until `sw_in` has been sampled for 7 edges. At edge 7, X..M = 1 and `chg`=1 for one cycle. `busy` is high from edge 3 to edge 6.
- **Glitch rejection.** Drive `sw_in[2]` (Z) high for 3 cycles, then low. Required: Z stays 0, `chg` never pulses, and `busy` returns to 0.
- **Independent bits.** Raise K at cycle 0 and M at cycle 2. Required: K rises at edge 7 and M at edge 9, each with its own one-cycle `chg` pulse.
- **Freeze.** Assert `freeze`, toggle X to 1 for 20 cycles, then deassert `freeze`. Required: X stays 0 while frozen. X becomes 1 on the first edge after the deassert, with a single `chg` pulse.
- **Freeze without net change.** Under `freeze`, toggle Y high and back low, each level held for 10 cycles, then release. Required: no `chg` pulse and Y stays 0.
- **Reset mid-debounce.** Pulse `rst_n` low at cycle 4 of a debounce. Required: `busy` drops to 0 at once. After release, the still-high input takes a full 7-edge latency to appear.

Source files
------------

// File: rtl/sw_conditioner.sv
// Five-line switch conditioner: 2-FF synchroniser, per-bit debounce and a
// freezable output register with a one-cycle change strobe.
module sw_conditioner #(
    parameter int DEBOUNCE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sw_in,
    input  logic       freeze,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic       K,
    output logic       M,
    output logic       chg,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [4:0]       s1;
    logic [4:0]       s2;
    logic [4:0]       stb;
    logic [4:0]       out_q;
    logic [CNT_W-1:0] cnt [5];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would collapse s1/s2 into one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // A level is accepted only after DEBOUNCE consecutive mismatching samples;
    // any agreeing sample restarts the count, so short glitches leave no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == stb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // chg rises on the same edge out_q takes a new value; a frozen edge never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            chg   <= 1'b0;
        end else begin
            chg <= 1'b0;
            if (!freeze) begin
                out_q <= stb;
                chg   <= (stb != out_q);
            end
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < 5; i++) busy = busy | (cnt[i] != '0);
    end

    assign {X, Y, Z, K, M} = out_q;

endmodule
